// File: rtl/uart_tx_arbiter_if.sv
// Request/transmitter bundle for uart_tx_arbiter: two requesters, the TX load
// path and the arbiter status flags.
interface uart_tx_arbiter_if #(
    parameter int D_WIDTH = 8
);
    logic                   req0_valid;
    logic [D_WIDTH-1:0]     req0_data;
    logic                   req0_ack;
    logic                   req1_valid;
    logic [2*D_WIDTH-1:0]   req1_data;
    logic                   req1_ack;
    logic [D_WIDTH-1:0]     tx_p_data;
    logic                   tx_data_valid;
    logic                   tx_busy;
    logic                   arb_busy;
    logic                   grant_id;
    logic                   timeout_err;

    // Requester/transmitter side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ack, req1_ack, tx_p_data, tx_data_valid,
               arb_busy, grant_id, timeout_err
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ack, req1_ack, tx_p_data, tx_data_valid,
               arb_busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for the UART transmitter: one-byte req0, two-byte req1
// (LSB first). Optional load-to-busy watchdog enabled by ARB_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int D_WIDTH     = 8,
    parameter int TIMEOUT_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]           state_r, state_s;
    logic [2*D_WIDTH-1:0] data_buf_r, data_buf_s;
    logic                 bytes_left_r, bytes_left_s;
    logic                 last_grant_r, last_grant_s;
    logic                 grant_id_r, grant_id_s;
    logic                 req0_ack_r, req0_ack_s;
    logic                 req1_ack_r, req1_ack_s;
    logic                 tx_valid_r, tx_valid_s;
    logic [D_WIDTH-1:0]   tx_p_data_r, tx_p_data_s;
    logic                 arb_busy_r, arb_busy_s;

`ifdef ARB_TX_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    logic [CNT_W-1:0]            cnt_r, cnt_s;
    logic                        timeout_err_r, timeout_err_s;
`endif

    // Next-state and next-output logic for the transfer sequencer
    always_comb begin
        state_s      = state_r;
        data_buf_s   = data_buf_r;
        bytes_left_s = bytes_left_r;
        last_grant_s = last_grant_r;
        grant_id_s   = grant_id_r;
        req0_ack_s   = 1'b0;
        req1_ack_s   = 1'b0;
        tx_valid_s   = 1'b0;
        tx_p_data_s  = tx_p_data_r;
`ifdef ARB_TX_TIMEOUT_EN
        cnt_s         = cnt_r;
        timeout_err_s = timeout_err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // On a tie the requester that did not win last time goes first
                if (bus.req0_valid && (!bus.req1_valid || last_grant_r)) begin
                    req0_ack_s   = 1'b1;
                    data_buf_s   = {{D_WIDTH{1'b0}}, bus.req0_data};
                    bytes_left_s = 1'b0;
                    last_grant_s = 1'b0;
                    grant_id_s   = 1'b0;
                    state_s      = ST_LOAD;
                end else if (bus.req1_valid) begin
                    req1_ack_s   = 1'b1;
                    data_buf_s   = bus.req1_data;
                    bytes_left_s = 1'b1;
                    last_grant_s = 1'b1;
                    grant_id_s   = 1'b1;
                    state_s      = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!bus.tx_busy) begin
                    tx_valid_s  = 1'b1;
                    tx_p_data_s = data_buf_r[D_WIDTH-1:0];
                    state_s     = ST_WAIT_HI;
`ifdef ARB_TX_TIMEOUT_EN
                    cnt_s = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_s = ST_WAIT_LO;
`ifdef ARB_TX_TIMEOUT_EN
                end else if (cnt_r == CNT_LAST) begin
                    // Transmitter never took the byte: abandon the rest
                    timeout_err_s = 1'b1;
                    bytes_left_s  = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
`else
                end else begin
                    state_s = ST_WAIT_HI;
`endif
                end
            end
            ST_WAIT_LO: begin
                if (bus.tx_busy) begin
                    state_s = ST_WAIT_LO;
                end else if (bytes_left_r) begin
                    data_buf_s   = {{D_WIDTH{1'b0}}, data_buf_r[2*D_WIDTH-1:D_WIDTH]};
                    bytes_left_s = 1'b0;
                    state_s      = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        arb_busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; reset drops any buffered byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            data_buf_r   <= {(2*D_WIDTH){1'b0}};
            bytes_left_r <= 1'b0;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            req0_ack_r   <= 1'b0;
            req1_ack_r   <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_p_data_r  <= {D_WIDTH{1'b0}};
            arb_busy_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            data_buf_r   <= data_buf_s;
            bytes_left_r <= bytes_left_s;
            last_grant_r <= last_grant_s;
            grant_id_r   <= grant_id_s;
            req0_ack_r   <= req0_ack_s;
            req1_ack_r   <= req1_ack_s;
            tx_valid_r   <= tx_valid_s;
            tx_p_data_r  <= tx_p_data_s;
            arb_busy_r   <= arb_busy_s;
        end
    end

`ifdef ARB_TX_TIMEOUT_EN
    // Load-to-busy watchdog counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            cnt_r         <= cnt_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.req0_ack      = req0_ack_r;
    assign bus.req1_ack      = req1_ack_r;
    assign bus.tx_data_valid = tx_valid_r;
    assign bus.tx_p_data     = tx_p_data_r;
    assign bus.arb_busy      = arb_busy_r;
    assign bus.grant_id      = grant_id_r;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Front-end scheduler for the UART transmitter. Two requesters share one TX path: the register-file read path (one byte) and the ALU result path (two bytes, LSB first). The block arbitrates round-robin, captures the winning request into a local buffer and sequences one or two frames into the transmitter. It drives the transmitter's parallel data and valid, and tracks completion from its busy output.

## Interface
Parameters:
- D_WIDTH, 8, frame data width in bits
- TIMEOUT_CYC, 4, cycles to wait for tx_busy to rise after a load pulse (used only with ARB_TX_TIMEOUT_EN)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  byte request from register-file read path; held until req0_ack
- req0_data  in  D_WIDTH  byte to send
- req0_ack  out  1  one-cycle pulse: req0_data captured
- req1_valid  in  1  two-byte request from ALU path; held until req1_ack
- req1_data  in  2*D_WIDTH  word to send; [D_WIDTH-1:0] first
- req1_ack  out  1  one-cycle pulse: req1_data captured
- tx_p_data  out  D_WIDTH  parallel data to transmitter
- tx_data_valid  out  1  one-cycle load pulse to transmitter
- tx_busy  in  1  transmitter busy
- arb_busy  out  1  high in any state other than IDLE
- grant_id  out  1  owner of the current transfer (0 = req0, 1 = req1)
- timeout_err  out  1  sticky error flag; constant 0 without ARB_TX_TIMEOUT_EN

## Operation
- States: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - On any valid request, grant one requester, pulse its ack and latch its data into buf (2*D_WIDTH bits, zero-extended for req0).
  - Set bytes_left to 0 for req0 or 1 for req1. Go to LOAD.
- Arbitration: last_grant resets to 1, so req0 wins the first tie. When both requests are valid, grant the requester that is not last_grant. Update last_grant on every grant.
- LOAD:
  - If tx_busy = 0: assert tx_data_valid for one cycle with tx_p_data = buf[D_WIDTH-1:0], then go to WAIT_HI.
  - If tx_busy = 1: hold in LOAD with no pulse.
- WAIT_HI: wait for tx_busy = 1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy = 0.
  - If bytes_left = 1: shift buf right by D_WIDTH, clear bytes_left, go to LOAD.
  - Otherwise go to IDLE.
- Requests arriving while arb_busy = 1 are not acked. They stay pending until the state returns to IDLE.
- tx_p_data is registered and holds its last value outside load pulses.

## Timing
- Reset values: req0_ack = 0, req1_ack = 0, tx_data_valid = 0, tx_p_data = 0, arb_busy = 0, grant_id = 0, timeout_err = 0. State is IDLE, last_grant = 1, buf = 0, bytes_left = 0.
- Latency:
  - Request sampled in IDLE at cycle N: ack at cycle N+1 (registered).
  - tx_data_valid at cycle N+2 at the earliest.
- Second byte of req1: tx_data_valid no earlier than 1 cycle after tx_busy is sampled low in WAIT_LO.
- Back-to-back transfers: a request pending at return to IDLE is granted in the first IDLE cycle. Minimum 1 IDLE cycle between transfers.
- Ack and valid overlap: a requester sees ack while its valid is still high and must drop or replace valid on the next cycle. A valid held high after ack is treated as a new request.
- Reset mid-transfer forces IDLE immediately:
  - Any buffered byte is dropped.
  - Outputs return to their reset values.
  - The transmitter is not aborted.

## Configuration
- ARB_TX_TIMEOUT_EN defined:
  - A counter runs in WAIT_HI.
  - If tx_busy is not seen high within TIMEOUT_CYC cycles after the load pulse, set timeout_err (sticky until rst), drop the remainder of the transfer and return to IDLE.
- ARB_TX_TIMEOUT_EN undefined:
  - WAIT_HI waits indefinitely.
  - No counter is built; timeout_err is tied to 0.

## Test plan
- req0_valid with 0xA5, transmitter idle → req0_ack one cycle later; one tx_data_valid with tx_p_data = 0xA5; arb_busy falls after tx_busy falls.
- req1_valid with 0x1234 → req1_ack; first load 0x34, then after tx_busy falls a second load 0x12; exactly two pulses.
- req0 and req1 both valid from reset → req0 granted first, then req1. Repeat the tie → req0 again, because last_grant = 1 after the req1 transfer.
- tx_busy held high on entry to LOAD for 5 cycles → no tx_data_valid until the cycle after tx_busy drops.
- rst asserted in WAIT_LO between the two bytes of 0xBEEF → all outputs 0 asynchronously, and 0xBE is never loaded.
- With ARB_TX_TIMEOUT_EN, TIMEOUT_CYC = 4 and tx_busy stuck low → timeout_err = 1 after 4 cycles, state IDLE, next request still served.
